// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and request legality check for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} lsu_state_t;
  function automatic logic req_err(input logic write, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3, mis;
    bad_f3 = write ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return bad_f3 || mis;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian load extraction/extension and sub-word store merge
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);
  logic [4:0]  w_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_sh   = {i_addr_lo, 3'b000};
  assign w_byte = 8'(i_old >> w_sh);
  assign w_half = i_addr_lo[1] ? i_old[31:16] : i_old[15:0];
  assign o_load = i_funct3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
                  i_funct3 == F3_BU ? {24'b0, w_byte} :
                  i_funct3 == F3_H  ? {{16{w_half[15]}}, w_half} :
                  i_funct3 == F3_HU ? {16'b0, w_half} : i_old;
  assign o_store = i_funct3 == F3_B ? (i_old & ~(32'hFF << w_sh)) | ({24'b0, i_wdata[7:0]} << w_sh) :
                   i_funct3 == F3_H ? (i_addr_lo[1] ? {i_wdata[15:0], i_old[15:0]} : {i_old[31:16], i_wdata[15:0]}) :
                   i_wdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator with read-modify-write for sub-word stores
module load_store_unit import lsu_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  lsu_state_t  r_state, w_next;
  logic [31:0] addr_q, wdata_q, merge_q, r_rdata;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic        w_accept;
  logic [31:0] w_old, w_load, w_store;
  assign w_accept = req_valid && r_state == IDLE;
  assign w_old = r_state == READ ? mem_read_data : merge_q;
  lsu_align u_align (
    .i_funct3 (funct3_q),
    .i_addr_lo(addr_q[1:0]),
    .i_old    (w_old),
    .i_wdata  (wdata_q),
    .o_load   (w_load),
    .o_store  (w_store)
  );
  // next-state: errors bypass memory, SW skips the read, loads and SB/SH read first
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = req_err(req_write, req_funct3, req_addr[1:0]) ? ERR :
                                       (req_write && req_funct3 == F3_W) ? WRITE : READ;
      READ:    w_next = write_q ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // state register; async reset drops any in-flight write strobe at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // request capture, old-word capture for merges, and response data update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      merge_q  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        write_q  <= req_write;
        if (w_next == ERR) r_rdata <= '0;
      end
      if (r_state == READ && write_q) merge_q <= mem_read_data;
      if (r_state == READ && !write_q) r_rdata <= w_load;
      if (r_state == WRITE) r_rdata <= '0;
    end
  end
  assign req_ready      = r_state == IDLE;
  assign resp_valid     = r_state == RESP || r_state == ERR;
  assign resp_error     = r_state == ERR;
  assign resp_rdata     = r_rdata;
  assign mem_read       = r_state == READ;
  assign mem_write      = r_state == WRITE;
  assign mem_address    = r_state == IDLE ? 32'b0 : {addr_q[31:2], 2'b00};
  assign mem_write_data = r_state == WRITE ? w_store : 32'b0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of loads, sub-word stores, errors and reset abort
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;
  int resp_at, rd_n, wr_n, rd_at, wr_at, busy_n;
  logic [31:0] rdata, wr_data, rd_addr, wr_addr;
  logic err;
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );
  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
  task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    resp_at = 0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0; busy_n = 0;
    rdata = 'x; err = 1'bx; wr_data = 'x; rd_addr = 'x; wr_addr = 'x;
    for (int k = 1; k <= 8 && resp_at == 0; k++) begin
      @(negedge clk);
      if (mem_read) begin rd_n++; if (rd_at == 0) begin rd_at = k; rd_addr = mem_address; end end
      if (mem_write) begin wr_n++; if (wr_at == 0) begin wr_at = k; wr_data = mem_write_data; wr_addr = mem_address; end end
      if (!req_ready) busy_n++;
      if (resp_valid) begin resp_at = k; rdata = resp_rdata; err = resp_error; end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    checks++; if ({resp_valid, resp_error, mem_read, mem_write} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0000", {resp_valid, resp_error, mem_read, mem_write}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    checks++; if ({mem_address, mem_write_data} !== 64'h0) begin errors++; $display("FAIL rst_mem_bus got %h %h exp 0 0", mem_address, mem_write_data); end
    rst_n = 1'b1;
  endtask
  task automatic test_lb_lbu;
    run(1'b0, 3'b000, 32'h190, 32'h0);
    checks++; if (resp_at !== 2 || err !== 1'b0) begin errors++; $display("FAIL lb_timing got resp@%0d err %b exp resp@2 err 0", resp_at, err); end
    checks++; if (rdata !== 32'hFFFFFFEA) begin errors++; $display("FAIL lb_data got %h exp ffffffea", rdata); end
    checks++; if (rd_n !== 1 || wr_n !== 0 || rd_addr !== 32'h190) begin errors++; $display("FAIL lb_mem got rd %0d wr %0d addr %h exp rd 1 wr 0 addr 190", rd_n, wr_n, rd_addr); end
    run(1'b0, 3'b100, 32'h190, 32'h0);
    checks++; if (rdata !== 32'h000000EA || resp_at !== 2) begin errors++; $display("FAIL lbu_data got %h resp@%0d exp 000000ea resp@2", rdata, resp_at); end
    checks++; if (rd_n !== 1 || wr_n !== 0) begin errors++; $display("FAIL lbu_mem got rd %0d wr %0d exp rd 1 wr 0", rd_n, wr_n); end
  endtask
  task automatic test_sb_merge;
    run(1'b1, 3'b000, 32'h1A1, 32'h00000055);
    checks++; if (rd_at !== 1 || wr_at !== 2 || resp_at !== 3) begin errors++; $display("FAIL sb_timing got rd@%0d wr@%0d resp@%0d exp 1 2 3", rd_at, wr_at, resp_at); end
    checks++; if (wr_data !== 32'h0000553D || wr_addr !== 32'h1A0) begin errors++; $display("FAIL sb_wdata got %h @%h exp 0000553d @1a0", wr_data, wr_addr); end
    checks++; if (rd_n !== 1 || wr_n !== 1 || busy_n !== 3) begin errors++; $display("FAIL sb_counts got rd %0d wr %0d busy %0d exp 1 1 3", rd_n, wr_n, busy_n); end
    checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sb_resp got %h err %b exp 0 err 0", rdata, err); end
    run(1'b0, 3'b010, 32'h1A0, 32'h0);
    checks++; if (rdata !== 32'h0000553D || resp_at !== 2) begin errors++; $display("FAIL lw_after_sb got %h resp@%0d exp 0000553d resp@2", rdata, resp_at); end
  endtask
  task automatic test_lh;
    run(1'b0, 3'b001, 32'h1AA, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL lh_upper got %h exp 00000000", rdata); end
    run(1'b0, 3'b001, 32'h1A8, 32'h0);
    checks++; if (rdata !== 32'h00001407) begin errors++; $display("FAIL lh_lower got %h exp 00001407", rdata); end
  endtask
  task automatic test_sh;
    run(1'b1, 3'b001, 32'h1A8, 32'h00008001);
    checks++; if (wr_data !== 32'h00008001 || resp_at !== 3) begin errors++; $display("FAIL sh_wdata got %h resp@%0d exp 00008001 resp@3", wr_data, resp_at); end
    checks++; if (mem['h1A8 >> 2] !== 32'h00008001) begin errors++; $display("FAIL sh_memword got %h exp 00008001", mem['h1A8 >> 2]); end
    run(1'b0, 3'b001, 32'h1A8, 32'h0);
    checks++; if (rdata !== 32'hFFFF8001) begin errors++; $display("FAIL sh_lh got %h exp ffff8001", rdata); end
    run(1'b0, 3'b101, 32'h1A8, 32'h0);
    checks++; if (rdata !== 32'h00008001) begin errors++; $display("FAIL sh_lhu got %h exp 00008001", rdata); end
  endtask
  task automatic test_sw;
    run(1'b1, 3'b010, 32'h1B4, 32'hCAFEF00D);
    checks++; if (rd_n !== 0 || wr_at !== 1 || resp_at !== 2 || wr_data !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_path got rd %0d wr@%0d resp@%0d data %h exp 0 1 2 cafef00d", rd_n, wr_at, resp_at, wr_data); end
  endtask
  task automatic test_errors;
    run(1'b0, 3'b010, 32'h192, 32'h0);
    checks++; if (resp_at !== 1 || err !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL lw_misalign got resp@%0d err %b data %h exp resp@1 err 1 data 0", resp_at, err, rdata); end
    checks++; if (rd_n !== 0 || wr_n !== 0) begin errors++; $display("FAIL lw_misalign_mem got rd %0d wr %0d exp 0 0", rd_n, wr_n); end
    run(1'b0, 3'b101, 32'h1A8, 32'h0);
    run(1'b1, 3'b001, 32'h1A3, 32'h0000FFFF);
    checks++; if (resp_at !== 1 || err !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL sh_misalign got resp@%0d err %b data %h exp resp@1 err 1 data 0", resp_at, err, rdata); end
    checks++; if (rd_n !== 0 || wr_n !== 0) begin errors++; $display("FAIL sh_misalign_mem got rd %0d wr %0d exp 0 0", rd_n, wr_n); end
    run(1'b1, 3'b100, 32'h1A0, 32'h0);
    checks++; if (resp_at !== 1 || err !== 1'b1 || wr_n !== 0) begin errors++; $display("FAIL st_reserved got resp@%0d err %b wr %0d exp resp@1 err 1 wr 0", resp_at, err, wr_n); end
    run(1'b0, 3'b110, 32'h1A0, 32'h0);
    checks++; if (resp_at !== 1 || err !== 1'b1 || rd_n !== 0) begin errors++; $display("FAIL ld_reserved got resp@%0d err %b rd %0d exp resp@1 err 1 rd 0", resp_at, err, rd_n); end
  endtask
  task automatic test_reset_abort;
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1B0; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1 || mem_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL abort_inwrite got wr %b data %h exp 1 deadbeef", mem_write, mem_write_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_async got wr %b ready %b exp 0 1", mem_write, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (mem['h1B0 >> 2] !== 32'h00000022) begin errors++; $display("FAIL abort_memword got %h exp 00000022", mem['h1B0 >> 2]); end
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_noresp got resp_seen %b ready %b exp 0 1", seen, req_ready); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem['h190 >> 2] = 32'h000000EA;
    mem['h1A0 >> 2] = 32'h0000093D;
    mem['h1A8 >> 2] = 32'h00001407;
    mem['h1B0 >> 2] = 32'h00000022;
    test_reset;
    test_lb_lbu;
    test_sb_merge;
    test_lh;
    test_sh;
    test_sw;
    test_errors;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. It accepts one load or store request at a time from the core. It drives the word-wide data memory through `mem_read`/`mem_write`, using a read-modify-write sequence for byte and halfword stores. It returns sign- or zero-extended load data with a single-cycle response pulse. It sits between the execute stage and the data memory, which reads combinationally and writes on the rising clock edge.

## Interface

- No parameters. Data and address widths are fixed at 32 bits.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: high only in IDLE. The request is accepted on `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V width code.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data. The byte lane(s) used are the LSBs.
- `resp_valid` out 1: one-cycle completion pulse. There is no backpressure.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_error` out 1: misaligned or reserved funct3. Qualified by `resp_valid`.
- `mem_read` out 1: read strobe to data memory.
- `mem_write` out 1: write strobe to data memory.
- `mem_address` out 32: word-aligned address, `{addr_q[31:2], 2'b00}`.
- `mem_write_data` out 32: full word to write.
- `mem_read_data` in 32: combinational read data from memory.

## Operation

- The request is captured into registers on acceptance: `addr_q`, `wdata_q`, `funct3_q`, `write_q`.
- States:
  - IDLE → ERR if the request is misaligned or the funct3 is reserved.
  - IDLE → WRITE for SW.
  - IDLE → READ for any load, SB or SH.
  - READ → RESP for loads. Load data is captured at the end of READ.
  - READ → WRITE for SB/SH. The old word is captured into `merge_q`.
  - WRITE → RESP.
  - ERR → IDLE, with `resp_valid=1` and `resp_error=1`.
  - RESP → IDLE, with `resp_valid=1`.
- Strobes are decoded from state:
  - `mem_read` = (state==READ).
  - `mem_write` = (state==WRITE).
  - The two strobes are never high together.
- Misalignment rules:
  - LH/LHU/SH with `addr[0]=1` is misaligned.
  - LW/SW with `addr[1:0]≠0` is misaligned.
  - Errors produce no memory access.
- Reserved funct3 codes: loads 011, 110, 111; stores 011 and all codes 1xx.
- Byte lanes are little-endian:
  - Bytes are selected by `addr[1:0]`.
  - Halfwords are selected by `addr[1]`.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
- Store merge:
  - SB replaces byte lane `addr[1:0]` of `merge_q` with `wdata_q[7:0]`.
  - SH replaces half `addr[1]` with `wdata_q[15:0]`.
  - SW writes `wdata_q` unchanged.
- `mem_address` and `mem_write_data` are 0 in IDLE.

## Timing

- Request accepted at edge T.
- Response `resp_valid` appears at:
  - ERR: T+1.
  - LW/LH/LB and SW: T+2.
  - SB/SH: T+3.
- The next request can be accepted in the cycle after RESP/ERR, since `req_ready` rises with the return to IDLE.
- Reset values:
  - state = IDLE.
  - `req_ready=1`.
  - `resp_valid=0`, `resp_error=0`, `resp_rdata=0`.
  - `mem_read=0`, `mem_write=0`, `mem_address=0`, `mem_write_data=0`.
- `resp_rdata` is registered and holds its value until the next response.
- Reset mid-operation forces IDLE immediately. `mem_write` drops asynchronously, so an aborted SB/SH/SW modifies no memory word, and no response is issued.
- `req_*` inputs are ignored while `req_ready=0`.

## Structure

- `lsu_pkg` holds:
  - The funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The state enum `lsu_state_t` {IDLE, READ, WRITE, RESP, ERR}.
- Sub-module `lsu_align` is purely combinational. It performs load extraction/extension and store merge, given funct3, `addr[1:0]`, the old word and the store data.
- `load_store_unit` contains the FSM, the request registers, `merge_q` and the response registers.

## Test plan

- Memory model word at 0x190 = 0x000000EA:
  - LB @0x190 → `resp_rdata`=0xFFFFFFEA at T+2.
  - LBU @0x190 → 0x000000EA.
  - Exactly one `mem_read` cycle each.
- Word at 0x1A0 = 0x0000093D; SB `wdata`=0x55 @0x1A1:
  - `mem_read` at T+1, `mem_write` at T+2 with `mem_write_data`=0x0000553D, `resp_valid` at T+3.
  - A following LW @0x1A0 returns 0x0000553D.
- Word at 0x1A8 = 0x00001407; LH @0x1AA → 0x00000000, LH @0x1A8 → 0x00001407.
- SH 0x8001 @0x1A8 → word 0x00008001. LH @0x1A8 → 0xFFFF8001; LHU → 0x00008001.
- LW @0x192 and SH @0x1A3 → `resp_error=1`, `resp_rdata=0` at T+1, with `mem_read` and `mem_write` never asserted.
- Assert `rst_n=0` during WRITE of SW 0xDEADBEEF @0x1B0 (old 0x00000022):
  - `mem_write` falls immediately and the word stays 0x00000022.
  - After reset release, `req_ready=1` and no `resp_valid` appears.
